data_cache: RTL and testbench

Direct-mapped, write-back, write-allocate L1 data cache between the RV32IM MEM stage and the 128-bit block data memory. It serves byte, halfword and word loads and stores from the core in the hit cycle. On a miss it stalls the pipeline via `BUSYWAIT`, writes back a dirty victim line, fetches the new 16-byte line, then completes the access.

---
 rtl/data_cache.sv | 176 +++++++++++++++++
 tb/tb_data_cache.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-back write-allocate L1 data cache; DCACHE_STATS_EN adds HIT_COUNT/MISS_COUNT
module data_cache #(
   parameter int SETS = 8
) (
   input  logic         CLOCK,
   input  logic         RESET,
   input  logic         READ,
   input  logic         WRITE,
   input  logic [2:0]   FUNC3,
   input  logic [31:0]  ADDRESS,
   input  logic [31:0]  WRITEDATA,
   output logic [31:0]  READDATA,
   output logic         BUSYWAIT,
   output logic         MEM_READ,
   output logic         MEM_WRITE,
   output logic [27:0]  MEM_ADDRESS,
   output logic [127:0] MEM_WRITEDATA,
   input  logic [127:0] MEM_READDATA,
   input  logic         MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]  HIT_COUNT,
   output logic [31:0]  MISS_COUNT
`endif
);
   localparam int IW = $clog2(SETS);
   localparam int TW = 28 - IW;

   typedef enum logic [1:0] {IDLE, WRITE_BACK, FETCH, UPDATE} state_t;
   state_t state, state_next;

   logic [SETS-1:0] valid_bits;
   logic [SETS-1:0] dirty_bits;
   logic [TW-1:0]   tag_array  [SETS];
   logic [127:0]    data_array [SETS];

   logic [IW-1:0] index;
   logic [TW-1:0] tag;
   logic [1:0]    word_sel;
   logic          request;
   logic          hit;
   logic          store_hit;
   logic [127:0]  cur_line;
   logic [31:0]   cur_word;

   assign index     = ADDRESS[3+IW:4];
   assign tag       = ADDRESS[31:4+IW];
   assign word_sel  = ADDRESS[3:2];
   assign request   = READ ^ WRITE;
   assign hit       = valid_bits[index] && (tag_array[index] == tag);
   assign cur_line  = data_array[index];
   assign cur_word  = cur_line[{word_sel, 5'b00000} +: 32];
   assign store_hit = (state == IDLE) && WRITE && !READ && hit;

   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] load_value;

   always_comb begin
      load_byte = cur_word[{ADDRESS[1:0], 3'b000} +: 8];
      load_half = ADDRESS[1] ? cur_word[31:16] : cur_word[15:0];
      case (FUNC3)
         3'b000:  load_value = {{24{load_byte[7]}}, load_byte};
         3'b001:  load_value = {{16{load_half[15]}}, load_half};
         3'b100:  load_value = {24'd0, load_byte};
         3'b101:  load_value = {16'd0, load_half};
         default: load_value = cur_word;
      endcase
   end

   assign READDATA = (READ && !WRITE && hit && state == IDLE) ? load_value : 32'd0;

   // Store data is right-aligned; lane placement comes from the low address bits.
   logic [31:0]  store_word;
   logic [127:0] store_line;

   always_comb begin
      store_word = cur_word;
      case (FUNC3[1:0])
         2'b00:   store_word[{ADDRESS[1:0], 3'b000} +: 8] = WRITEDATA[7:0];
         2'b01:   store_word[{ADDRESS[1], 4'b0000} +: 16] = WRITEDATA[15:0];
         default: store_word = WRITEDATA;
      endcase
      store_line = cur_line;
      store_line[{word_sel, 5'b00000} +: 32] = store_word;
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (request && !hit)
               state_next = (valid_bits[index] && dirty_bits[index]) ? WRITE_BACK : FETCH;
         end
         WRITE_BACK: if (!MEM_BUSYWAIT) state_next = FETCH;
         FETCH:      if (!MEM_BUSYWAIT) state_next = UPDATE;
         UPDATE:     state_next = IDLE;
         default:    state_next = IDLE;
      endcase
   end

   always_comb begin
      BUSYWAIT      = 1'b0;
      MEM_READ      = 1'b0;
      MEM_WRITE     = 1'b0;
      MEM_ADDRESS   = 28'd0;
      MEM_WRITEDATA = 128'd0;
      case (state)
         IDLE:       BUSYWAIT = request && !hit;
         WRITE_BACK: begin
            BUSYWAIT      = 1'b1;
            MEM_WRITE     = 1'b1;
            MEM_ADDRESS   = {tag_array[index], index};
            MEM_WRITEDATA = cur_line;
         end
         FETCH: begin
            BUSYWAIT    = 1'b1;
            MEM_READ    = 1'b1;
            MEM_ADDRESS = {tag, index};
         end
         UPDATE:     BUSYWAIT = 1'b1;
         default:    BUSYWAIT = 1'b0;
      endcase
      // The stall must drop while reset is held even if the core keeps its request up.
      if (RESET) BUSYWAIT = 1'b0;
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         valid_bits <= '0;
         dirty_bits <= '0;
      end else if (state == UPDATE) begin
         valid_bits[index] <= 1'b1;
         dirty_bits[index] <= 1'b0;
      end else if (store_hit) begin
         dirty_bits[index] <= 1'b1;
      end
   end

   always_ff @(posedge CLOCK) begin
      if (state == UPDATE) begin
         data_array[index] <= MEM_READDATA;
         tag_array[index]  <= tag;
      end else if (store_hit) begin
         data_array[index] <= store_line;
      end
   end

`ifdef DCACHE_STATS_EN
   // The hit that completes a refilled access belongs to that miss, not to the hit tally.
   logic after_miss;

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         HIT_COUNT  <= 32'd0;
         MISS_COUNT <= 32'd0;
         after_miss <= 1'b0;
      end else if (state == IDLE && request) begin
         if (!hit) begin
            MISS_COUNT <= MISS_COUNT + 32'd1;
            after_miss <= 1'b1;
         end else if (after_miss) begin
            after_miss <= 1'b0;
         end else begin
            HIT_COUNT <= HIT_COUNT + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - self-checking bench for data_cache against an architectural memory model
module tb_data_cache;
   localparam int LAT = 2;

   logic         CLOCK;
   logic         RESET;
   logic         READ;
   logic         WRITE;
   logic [2:0]   FUNC3;
   logic [31:0]  ADDRESS;
   logic [31:0]  WRITEDATA;
   logic [31:0]  READDATA;
   logic         BUSYWAIT;
   logic         MEM_READ;
   logic         MEM_WRITE;
   logic [27:0]  MEM_ADDRESS;
   logic [127:0] MEM_WRITEDATA;
   logic [127:0] MEM_READDATA;
   logic         MEM_BUSYWAIT;
`ifdef DCACHE_STATS_EN
   logic [31:0]  HIT_COUNT;
   logic [31:0]  MISS_COUNT;
`endif

   data_cache dut (
      .CLOCK(CLOCK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .FUNC3(FUNC3),
      .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
      .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
      .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
      , .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
`endif
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [127:0] init_line(input logic [27:0] blk);
      logic [127:0] l;
      logic [15:0]  hi;
      for (int k = 0; k < 4; k++) begin
         hi = 16'hAAAA + 16'(16'h1111 * k);
         if (blk == 28'h4) l[k*32 +: 32] = {hi, 16'(k)};
         else              l[k*32 +: 32] = {4'h5, blk[23:0], 4'(k)};
      end
      return l;
   endfunction

   // Block memory: LAT busy cycles, transfer completes on the first edge with busywait low.
   logic [127:0] mem_store [logic [27:0]];
   int           mem_cnt = 0;
   logic [127:0] mem_rdata = 128'd0;

   function automatic logic [127:0] mem_line(input logic [27:0] a);
      if (mem_store.exists(a)) return mem_store[a];
      return init_line(a);
   endfunction

   assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mem_cnt < LAT);
   assign MEM_READDATA = mem_rdata;

   always @(posedge CLOCK) begin
      if (MEM_READ || MEM_WRITE) begin
         if (mem_cnt == LAT) begin
            mem_cnt <= 0;
            if (MEM_WRITE) mem_store[MEM_ADDRESS] = MEM_WRITEDATA;
            else           mem_rdata <= mem_line(MEM_ADDRESS);
         end else begin
            mem_cnt <= mem_cnt + 1;
         end
      end else begin
         mem_cnt <= 0;
      end
   end

   // Architectural view: what every word must hold from the core's point of view.
   logic [31:0] arch [logic [29:0]];
   logic        rv     [8];
   logic        rdirty [8];
   logic [24:0] rt     [8];
   int          m_hit  = 0;
   int          m_miss = 0;

   function automatic logic [31:0] arch_word(input logic [31:0] a);
      logic [127:0] l;
      int w;
      if (arch.exists(a[31:2])) return arch[a[31:2]];
      l = init_line(a[31:4]);
      w = int'(a[3:2]);
      return l[w*32 +: 32];
   endfunction

   function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] w;
      logic [7:0]  b;
      logic [15:0] h;
      int sb, sh;
      w  = arch_word(a);
      sb = int'(a[1:0]);
      sh = int'(a[1]);
      b  = w[sb*8 +: 8];
      h  = w[sh*16 +: 16];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b100:  return {24'd0, b};
         3'b101:  return {16'd0, h};
         default: return w;
      endcase
   endfunction

   task automatic store_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] w;
      int sb, sh;
      w  = arch_word(a);
      sb = int'(a[1:0]);
      sh = int'(a[1]);
      case (f3[1:0])
         2'b00:   w[sb*8 +: 8]   = d[7:0];
         2'b01:   w[sh*16 +: 16] = d[15:0];
         default: w = d;
      endcase
      arch[a[31:2]] = w;
   endtask

   function automatic logic [127:0] block_view(input logic [27:0] blk);
      logic [127:0] l;
      for (int k = 0; k < 4; k++) l[k*32 +: 32] = arch_word({blk, 4'b0000} + 32'(k*4));
      return l;
   endfunction

   logic [31:0]  exp_load    = 32'd0;
   logic         exp_wb_ok   = 1'b0;
   logic [27:0]  exp_wb_addr = 28'd0;
   logic [127:0] exp_wb_line = 128'd0;
   logic         exp_rd_ok   = 1'b0;
   logic [27:0]  exp_rd_addr = 28'd0;
   logic [27:0]  last_wb_addr = 28'd0;
   logic [31:0]  last_wb_w1   = 32'd0;
   logic [27:0]  last_rd_addr = 28'd0;

   always @(negedge CLOCK) begin
      if (RESET) begin
         chk("reset_busywait", 128'(BUSYWAIT), 128'(0));
         chk("reset_mem_req", 128'({MEM_READ, MEM_WRITE}), 128'(0));
      end else begin
         chk("mem_rd_wr_exclusive", 128'(MEM_READ & MEM_WRITE), 128'(0));
         chk("spurious_mem_write", 128'(MEM_WRITE & ~exp_wb_ok), 128'(0));
         chk("spurious_mem_read", 128'(MEM_READ & ~exp_rd_ok), 128'(0));
         if (MEM_WRITE) begin
            chk("wb_address", 128'(MEM_ADDRESS), 128'(exp_wb_addr));
            chk("wb_line", MEM_WRITEDATA, exp_wb_line);
         end
         if (MEM_READ) chk("fetch_address", 128'(MEM_ADDRESS), 128'(exp_rd_addr));
         if (READ && !WRITE && !BUSYWAIT) chk("readdata", 128'(READDATA), 128'(exp_load));
         if (!(READ ^ WRITE)) chk("no_req_busywait", 128'(BUSYWAIT), 128'(0));
         if (!(READ && !WRITE)) chk("no_load_readdata", 128'(READDATA), 128'(0));
      end
   end

   task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic use_lit, input logic [31:0] lit);
      logic [2:0]  ix;
      logic [24:0] tg;
      logic legal, miss, dirty, wb_seen, rd_seen;
      int stalls, exp_stalls;
      ix      = a[6:4];
      tg      = a[31:7];
      legal   = rd ^ wr;
      miss    = legal && !(rv[ix] && rt[ix] == tg);
      dirty   = miss && rv[ix] && rdirty[ix];
      stalls  = 0;
      wb_seen = 1'b0;
      rd_seen = 1'b0;
      exp_stalls  = !miss ? 0 : (dirty ? 2*LAT + 4 : LAT + 3);
      exp_load    = load_model(f3, a);
      exp_wb_ok   = dirty;
      exp_wb_addr = {rt[ix], ix};
      exp_wb_line = block_view({rt[ix], ix});
      exp_rd_ok   = miss;
      exp_rd_addr = a[31:4];
      if (miss) m_miss++;
      READ = rd; WRITE = wr; FUNC3 = f3; ADDRESS = a; WRITEDATA = wd;
      #1;
      chk("first_cycle_busywait", 128'(BUSYWAIT), 128'(miss));
      while (BUSYWAIT && stalls < 100) begin
         @(posedge CLOCK); #1;
         stalls++;
         if (MEM_WRITE) begin
            wb_seen = 1'b1;
            last_wb_addr = MEM_ADDRESS;
            last_wb_w1   = MEM_WRITEDATA[63:32];
         end
         if (MEM_READ) begin
            rd_seen = 1'b1;
            last_rd_addr = MEM_ADDRESS;
         end
      end
      chk("stall_cycles", 128'(stalls), 128'(exp_stalls));
      chk("writeback_seen", 128'(wb_seen), 128'(dirty));
      chk("fetch_seen", 128'(rd_seen), 128'(miss));
      if (use_lit) chk("literal_readdata", 128'(READDATA), 128'(lit));
      @(posedge CLOCK); #1;
      if (miss) begin rv[ix] = 1'b1; rt[ix] = tg; rdirty[ix] = 1'b0; end
      if (legal && !miss) m_hit++;
      if (legal && wr) begin store_model(f3, a, wd); rdirty[ix] = 1'b1; end
      READ = 1'b0; WRITE = 1'b0;
      exp_wb_ok = 1'b0; exp_rd_ok = 1'b0;
   endtask

   task automatic clear_model();
      for (int s = 0; s < 8; s++) begin
         // A dirty line lost to reset never reached memory.
         if (rv[s] && rdirty[s])
            for (int k = 0; k < 4; k++) arch.delete({rt[s], 3'(s), 2'(k)});
         rv[s] = 1'b0; rdirty[s] = 1'b0; rt[s] = 25'd0;
      end
   endtask

   initial begin
      int n;
      for (int s = 0; s < 8; s++) begin rv[s] = 1'b0; rdirty[s] = 1'b0; rt[s] = 25'd0; end
      RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; FUNC3 = 3'b010; ADDRESS = 32'd0; WRITEDATA = 32'd0;
      #12;
      chk("rst_busywait", 128'(BUSYWAIT), 128'(0));
      chk("rst_mem_read", 128'(MEM_READ), 128'(0));
      chk("rst_mem_write", 128'(MEM_WRITE), 128'(0));
      chk("rst_readdata", 128'(READDATA), 128'(0));
      @(posedge CLOCK); #1;
      RESET = 1'b0;
      @(posedge CLOCK); #1;

      access(1, 0, 3'b010, 32'h40, 32'h0, 1, 32'hAAAA0000);
      chk("first_fetch_addr", 128'(last_rd_addr), 128'(28'h4));
      access(0, 1, 3'b010, 32'h44, 32'h12345678, 0, 32'h0);
      access(1, 0, 3'b010, 32'h44, 32'h0, 1, 32'h12345678);
      access(0, 1, 3'b000, 32'h45, 32'h000000AB, 0, 32'h0);
      access(1, 0, 3'b010, 32'h44, 32'h0, 1, 32'h1234AB78);
      access(1, 0, 3'b000, 32'h45, 32'h0, 1, 32'hFFFFFFAB);
      access(1, 0, 3'b100, 32'h45, 32'h0, 1, 32'h000000AB);
      access(1, 0, 3'b001, 32'h44, 32'h0, 1, 32'hFFFFAB78);
      access(1, 0, 3'b101, 32'h44, 32'h0, 1, 32'h0000AB78);
      access(1, 1, 3'b010, 32'h44, 32'hDEADBEEF, 0, 32'h0);
      access(1, 0, 3'b010, 32'h44, 32'h0, 1, 32'h1234AB78);

      access(1, 0, 3'b010, 32'h440, 32'h0, 1, 32'h50000440);
      chk("evict_wb_addr", 128'(last_wb_addr), 128'(28'h4));
      chk("evict_wb_word1", 128'(last_wb_w1), 128'(32'h1234AB78));
      chk("evict_fetch_addr", 128'(last_rd_addr), 128'(28'h44));

      access(1, 0, 3'b010, 32'h84, 32'h0, 1, 32'h50000081);
      access(0, 1, 3'b001, 32'h86, 32'h0000BEEF, 0, 32'h0);
      access(1, 0, 3'b010, 32'h84, 32'h0, 1, 32'hBEEF0081);
      access(1, 0, 3'b001, 32'h87, 32'h0, 1, 32'hFFFFBEEF);
      access(1, 0, 3'b101, 32'h86, 32'h0, 1, 32'h0000BEEF);

      // Reset while the refill of 0x40 is in flight.
      exp_load = load_model(3'b010, 32'h40);
      exp_rd_ok = 1'b1; exp_rd_addr = 28'h4; exp_wb_ok = 1'b0;
      m_miss++;
      READ = 1'b1; WRITE = 1'b0; FUNC3 = 3'b010; ADDRESS = 32'h40;
      n = 0;
      #1;
      while (!MEM_READ && n < 20) begin @(posedge CLOCK); #1; n++; end
      chk("reset_test_fetch_started", 128'(MEM_READ), 128'(1));
`ifdef DCACHE_STATS_EN
      chk("hit_count", 128'(HIT_COUNT), 128'(m_hit));
      chk("miss_count", 128'(MISS_COUNT), 128'(m_miss));
`endif
      @(posedge CLOCK); #1;
      RESET = 1'b1;
      #1;
      chk("reset_drops_mem_read", 128'(MEM_READ), 128'(0));
      chk("reset_drops_busywait", 128'(BUSYWAIT), 128'(0));
      chk("reset_no_mem_write", 128'(MEM_WRITE), 128'(0));
`ifdef DCACHE_STATS_EN
      chk("reset_hit_count", 128'(HIT_COUNT), 128'(0));
      chk("reset_miss_count", 128'(MISS_COUNT), 128'(0));
`endif
      READ = 1'b0; exp_rd_ok = 1'b0;
      clear_model();
      @(posedge CLOCK); #1;
      RESET = 1'b0;
      @(posedge CLOCK); #1;

      access(1, 0, 3'b010, 32'h40, 32'h0, 1, 32'hAAAA0000);
      access(1, 0, 3'b010, 32'h44, 32'h0, 1, 32'h1234AB78);
      access(1, 0, 3'b010, 32'h84, 32'h0, 1, 32'h50000081);
      @(posedge CLOCK); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
